// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: ALU select codes, default widths
// and the per-operand forwarding source encoding.
package id_ex_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SLLV = 3'b110;
  localparam logic [2:0] ALU_SRAV = 3'b111;

  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Per-operand forwarding select: the younger EX/MEM result beats MEM/WB,
// and register 0 is never forwarded.
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] stored,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_alu_out,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic [DATA_W-1:0] data
);

  fwd_sel_e sel_s;

  // pick the forwarding source for this operand
  always_comb begin
    sel_s = FWD_NONE;
    if (exmem_reg_write && (exmem_rd != {REG_AW{1'b0}}) && (exmem_rd == src)) begin
      sel_s = FWD_EXMEM;
    end else if (memwb_reg_write && (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == src)) begin
      sel_s = FWD_MEMWB;
    end else begin
      sel_s = FWD_NONE;
    end
  end

  // route the selected source onto the operand
  always_comb begin
    data = stored;
    case (sel_s)
      FWD_EXMEM: data = exmem_alu_out;
      FWD_MEMWB: data = memwb_wdata;
      default:   data = stored;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand selection, forwarding and
// load-use hazard detection, feeding the ALU.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [2:0]        id_alu_sel,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              stall,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_alu_out,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_wdata,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_alu_in1,
  output logic [DATA_W-1:0] ex_alu_in2,
  output logic [2:0]        ex_alu_sel,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              load_use_stall
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] write_reg;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        shamt;
    logic [2:0]        alu_sel;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } stage_t;

  stage_t            stage_r;
  stage_t            stage_nxt_s;
  stage_t            load_s;
  logic [DATA_W-1:0] fwd_rs_s;
  logic [DATA_W-1:0] fwd_rt_s;

  assign load_use_stall = stage_r.valid && stage_r.mem_read &&
                          (stage_r.write_reg != {REG_AW{1'b0}}) &&
                          ((stage_r.write_reg == id_rs) || (stage_r.write_reg == id_rt)) &&
                          id_valid;

  // assemble the ID fields; the register file is not write-through, so the
  // value being written back this cycle is bypassed into the capture
  always_comb begin
    load_s            = '0;
    load_s.valid      = 1'b1;
    load_s.rs         = id_rs;
    load_s.rt         = id_rt;
    load_s.imm        = id_imm;
    load_s.shamt      = id_shamt;
    load_s.alu_sel    = id_alu_sel;
    load_s.alu_src    = id_alu_src;
    load_s.reg_write  = id_reg_write;
    load_s.mem_read   = id_mem_read;
    load_s.mem_write  = id_mem_write;
    load_s.mem_to_reg = id_mem_to_reg;
    if (id_reg_dst) load_s.write_reg = id_rd;
    else            load_s.write_reg = id_rt;
    if (memwb_reg_write && (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == id_rs)) load_s.rs_data = memwb_wdata;
    else                                                                       load_s.rs_data = id_rs_data;
    if (memwb_reg_write && (memwb_rd != {REG_AW{1'b0}}) && (memwb_rd == id_rt)) load_s.rt_data = memwb_wdata;
    else                                                                       load_s.rt_data = id_rt_data;
  end

  // next-state priority: flush, then stall, then bubble, then load
  always_comb begin
    stage_nxt_s = stage_r;
    if (flush) begin
      stage_nxt_s = '0;
    end else if (stall) begin
      stage_nxt_s = stage_r;
    end else if (load_use_stall || !id_valid) begin
      stage_nxt_s = '0;
    end else begin
      stage_nxt_s = load_s;
    end
  end

  // stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stage_r <= '0;
    else        stage_r <= stage_nxt_s;
  end

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src(stage_r.rs), .stored(stage_r.rs_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .data(fwd_rs_s)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src(stage_r.rt), .stored(stage_r.rt_data),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .data(fwd_rt_s)
  );

  // operand 2 is the immediate or the forwarded rt value
  always_comb begin
    if (stage_r.alu_src) ex_alu_in2 = stage_r.imm;
    else                 ex_alu_in2 = fwd_rt_s;
  end

  assign ex_valid      = stage_r.valid;
  assign ex_alu_in1    = fwd_rs_s;
  assign ex_store_data = fwd_rt_s;
  assign ex_alu_sel    = stage_r.alu_sel;
  assign ex_shamt      = stage_r.shamt;
  assign ex_write_reg  = stage_r.write_reg;
  assign ex_reg_write  = stage_r.reg_write;
  assign ex_mem_read   = stage_r.mem_read;
  assign ex_mem_write  = stage_r.mem_write;
  assign ex_mem_to_reg = stage_r.mem_to_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX outputs are queued when
// an instruction is driven and compared once the stage presents it.
module tb_id_ex_stage;

  localparam logic [2:0] A_ADD  = 3'b000;
  localparam logic [2:0] A_SUB  = 3'b010;
  localparam logic [2:0] A_AND  = 3'b011;
  localparam logic [2:0] A_OR   = 3'b100;
  localparam logic [2:0] A_SLL  = 3'b101;
  localparam logic [2:0] A_SRAV = 3'b111;

  typedef struct packed {
    logic v; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm;
    logic [4:0] sh; logic [2:0] sel; logic src, dst, rw, mr, mw, m2r;
  } id_t;

  typedef struct packed {
    logic v; logic [31:0] a1, a2, sd; logic [2:0] sel; logic [4:0] sh;
    logic [4:0] wr; logic rw, mr, mw, m2r;
  } exo_t;

  logic clk, rst_n;
  logic id_valid, id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0] id_rs, id_rt, id_rd, id_shamt;
  logic [2:0] id_alu_sel;
  logic stall, flush, exmem_reg_write, memwb_reg_write;
  logic [4:0] exmem_rd, memwb_rd;
  logic [31:0] exmem_alu_out, memwb_wdata;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_stall;
  logic [31:0] ex_alu_in1, ex_alu_in2, ex_store_data;
  logic [2:0] ex_alu_sel;
  logic [4:0] ex_shamt, ex_write_reg;

  int checks = 0;
  int errors = 0;
  exo_t sb[$];
  exo_t exp_v, obs_v;
  exo_t bub = '0;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_alu_sel(id_alu_sel), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_out(exmem_alu_out),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_wdata(memwb_wdata),
    .ex_valid(ex_valid), .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2),
    .ex_alu_sel(ex_alu_sel), .ex_shamt(ex_shamt), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .load_use_stall(load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1, "timeout");
  end

  function automatic id_t ins(input logic v, input logic [4:0] rs, rt, rd,
                              input logic [31:0] rsd, rtd, imm, input logic [4:0] sh,
                              input logic [2:0] sel, input logic src, dst, rw, mr, mw, m2r);
    ins = {v, rs, rt, rd, rsd, rtd, imm, sh, sel, src, dst, rw, mr, mw, m2r};
  endfunction

  function automatic exo_t mk(input logic v, input logic [31:0] a1, a2, sd, input logic [2:0] sel,
                              input logic [4:0] sh, wr, input logic rw, mr, mw, m2r);
    mk = {v, a1, a2, sd, sel, sh, wr, rw, mr, mw, m2r};
  endfunction

  function automatic exo_t observe();
    observe = {ex_valid, ex_alu_in1, ex_alu_in2, ex_store_data, ex_alu_sel, ex_shamt,
               ex_write_reg, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg};
  endfunction

  task automatic set_id(input id_t i);
    id_valid = i.v; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
    id_rs_data = i.rsd; id_rt_data = i.rtd; id_imm = i.imm; id_shamt = i.sh;
    id_alu_sel = i.sel; id_alu_src = i.src; id_reg_dst = i.dst;
    id_reg_write = i.rw; id_mem_read = i.mr; id_mem_write = i.mw; id_mem_to_reg = i.m2r;
  endtask

  task automatic idle_fwd();
    exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_alu_out = 32'd0;
    memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_wdata = 32'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0;
    idle_fwd();
    set_id(ins(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, A_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    #1 rst_n = 1'b0;
    #1;
    sb.push_back(bub);
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_state: got %h expected %h", obs_v, exp_v); end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL reset_lus: got %b expected 0", load_use_stall); end
    @(negedge clk) rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exmem_fwd();
    idle_fwd();
    set_id(ins(1'b1, 5'd8, 5'd2, 5'd10, 32'h11, 32'h22, 32'd0, 5'd0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 32'h55, 32'h22, 32'h22, A_ADD, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_alu_out = 32'h55;
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL exmem_fwd: got %h expected %h", obs_v, exp_v); end
    exmem_rd = 5'd0;
    sb.push_back(mk(1'b1, 32'h11, 32'h22, 32'h22, A_ADD, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL exmem_rd0: got %h expected %h", obs_v, exp_v); end
    memwb_reg_write = 1'b1; memwb_rd = 5'd2; memwb_wdata = 32'h77;
    sb.push_back(mk(1'b1, 32'h11, 32'h77, 32'h77, A_ADD, 5'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL memwb_fwd_rt: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_double_match();
    idle_fwd();
    set_id(ins(1'b1, 5'd1, 5'd9, 5'd4, 32'h3, 32'h99, 32'd0, 5'd0, A_SUB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 32'h3, 32'hA, 32'hA, A_SUB, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_alu_out = 32'hA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd9; memwb_wdata = 32'hB;
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL double_match: got %h expected %h", obs_v, exp_v); end
    exmem_reg_write = 1'b0;
    sb.push_back(mk(1'b1, 32'h3, 32'hB, 32'hB, A_SUB, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL memwb_only: got %h expected %h", obs_v, exp_v); end
    idle_fwd();
    set_id(ins(1'b1, 5'd1, 5'd9, 5'd0, 32'h3, 32'h99, 32'hFFFFFFF0, 5'd7, A_SLL, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(mk(1'b1, 32'h3, 32'hFFFFFFF0, 32'hA, A_SLL, 5'd7, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    exmem_reg_write = 1'b1; exmem_rd = 5'd9; exmem_alu_out = 32'hA;
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL imm_select: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_capture_bypass();
    idle_fwd();
    set_id(ins(1'b1, 5'd3, 5'd3, 5'd12, 32'd0, 32'd0, 32'd0, 5'd0, A_OR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    memwb_reg_write = 1'b1; memwb_rd = 5'd3; memwb_wdata = 32'h1234;
    sb.push_back(mk(1'b1, 32'h1234, 32'h1234, 32'h1234, A_OR, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    idle_fwd();
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL capture_bypass: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_load_use();
    idle_fwd();
    set_id(ins(1'b1, 5'd2, 5'd5, 5'd0, 32'h100, 32'h0, 32'h4, 5'd0, A_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1));
    sb.push_back(mk(1'b1, 32'h100, 32'h4, 32'h0, A_ADD, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1));
    tick();
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lw_in_ex: got %h expected %h", obs_v, exp_v); end
    set_id(ins(1'b1, 5'd5, 5'd6, 5'd7, 32'd0, 32'h6, 32'd0, 5'd0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    #1;
    checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_assert: got %b expected 1", load_use_stall); end
    sb.push_back(bub);
    tick();
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lus_bubble: got %h expected %h", obs_v, exp_v); end
    checks++;
    if (load_use_stall !== 1'b0) begin errors++; $display("FAIL lus_release: got %b expected 0", load_use_stall); end
    sb.push_back(mk(1'b1, 32'hCAFE, 32'h6, 32'h6, A_ADD, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    tick();
    memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_wdata = 32'hCAFE;
    #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lus_fwd: got %h expected %h", obs_v, exp_v); end
    idle_fwd();
  endtask

  task automatic test_stall_flush();
    exo_t exp_a, exp_lw;
    id_t lw_i, dep_i;
    idle_fwd();
    exp_a = mk(1'b1, 32'hF0, 32'h0F, 32'h0F, A_OR, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    set_id(ins(1'b1, 5'd1, 5'd2, 5'd3, 32'hF0, 32'h0F, 32'd0, 5'd0, A_OR, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(exp_a);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL stall_load: got %h expected %h", obs_v, exp_v); end
    set_id(ins(1'b1, 5'd4, 5'd5, 5'd6, 32'h1, 32'h2, 32'd0, 5'd0, A_AND, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0));
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      sb.push_back(exp_a);
      tick(); #1;
      exp_v = sb.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL stall_hold%0d: got %h expected %h", k, obs_v, exp_v); end
    end
    flush = 1'b1;
    sb.push_back(bub);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL stall_flush: got %h expected %h", obs_v, exp_v); end
    flush = 1'b0; stall = 1'b0;
    sb.push_back(mk(1'b1, 32'h1, 32'h2, 32'h2, A_AND, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0));
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL after_flush: got %h expected %h", obs_v, exp_v); end
    set_id(ins(1'b0, 5'd7, 5'd8, 5'd9, 32'h5, 32'h6, 32'h7, 5'd3, A_SUB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    sb.push_back(bub);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL id_invalid: got %h expected %h", obs_v, exp_v); end
    lw_i   = ins(1'b1, 5'd0, 5'd5, 5'd0, 32'd0, 32'd0, 32'h8, 5'd0, A_ADD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    exp_lw = mk(1'b1, 32'd0, 32'h8, 32'd0, A_ADD, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    dep_i  = ins(1'b1, 5'd0, 5'd5, 5'd7, 32'd0, 32'h1, 32'd0, 5'd0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    set_id(lw_i); sb.push_back(exp_lw);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lw2: got %h expected %h", obs_v, exp_v); end
    set_id(dep_i); stall = 1'b1;
    #1; checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_stall_a: got %b expected 1", load_use_stall); end
    sb.push_back(exp_lw);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lus_stall_hold: got %h expected %h", obs_v, exp_v); end
    checks++;
    if (load_use_stall !== 1'b1) begin errors++; $display("FAIL lus_stall_b: got %b expected 1", load_use_stall); end
    stall = 1'b0; sb.push_back(bub);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lus_after_stall: got %h expected %h", obs_v, exp_v); end
    set_id(lw_i); sb.push_back(exp_lw);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL lw3: got %h expected %h", obs_v, exp_v); end
    set_id(dep_i); flush = 1'b1; sb.push_back(bub);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL flush_lus: got %h expected %h", obs_v, exp_v); end
    flush = 1'b0;
    sb.push_back(mk(1'b1, 32'd0, 32'h1, 32'h1, A_ADD, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL dep_after_flush: got %h expected %h", obs_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    id_t  prog[3];
    exo_t want[3];
    idle_fwd();
    prog[0] = ins(1'b1, 5'd10, 5'd11, 5'd12, 32'h1000, 32'h2000, 32'd0, 5'd0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    want[0] = mk(1'b1, 32'h1000, 32'h2000, 32'h2000, A_ADD, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    prog[1] = ins(1'b1, 5'd13, 5'd14, 5'd15, 32'hAAAA5555, 32'h0000FFFF, 32'h10, 5'd3, A_SRAV, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    want[1] = mk(1'b1, 32'hAAAA5555, 32'h10, 32'h0000FFFF, A_SRAV, 5'd3, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    prog[2] = ins(1'b1, 5'd16, 5'd17, 5'd0, 32'h40, 32'hDEADBEEF, 32'h8, 5'd0, A_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    want[2] = mk(1'b1, 32'h40, 32'h8, 32'hDEADBEEF, A_ADD, 5'd0, 5'd17, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_id(prog[i]);
      sb.push_back(want[i]);
      tick(); #1;
      exp_v = sb.pop_front(); obs_v = observe(); checks++;
      if (obs_v !== exp_v) begin errors++; $display("FAIL back_to_back%0d: got %h expected %h", i, obs_v, exp_v); end
    end
  endtask

  task automatic test_reset_midstream();
    exo_t exp_i;
    idle_fwd();
    exp_i = mk(1'b1, 32'h1000, 32'h2000, 32'h2000, A_ADD, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    set_id(ins(1'b1, 5'd10, 5'd11, 5'd12, 32'h1000, 32'h2000, 32'd0, 5'd0, A_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    sb.push_back(exp_i);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL pre_reset: got %h expected %h", obs_v, exp_v); end
    #2 rst_n = 1'b0;
    #1;
    sb.push_back(bub);
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL async_reset: got %h expected %h", obs_v, exp_v); end
    sb.push_back(bub);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL reset_held: got %h expected %h", obs_v, exp_v); end
    rst_n = 1'b1;
    sb.push_back(exp_i);
    tick(); #1;
    exp_v = sb.pop_front(); obs_v = observe(); checks++;
    if (obs_v !== exp_v) begin errors++; $display("FAIL post_reset: got %h expected %h", obs_v, exp_v); end
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_double_match();
    test_capture_bypass();
    test_load_use();
    test_stall_flush();
    test_back_to_back();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
